// File: rtl/logic_unit_arbiter_if.sv
// Two-requester operand/result handshake bundle
// for the shared bitwise logic unit.
interface logic_unit_arbiter_if #(
  parameter int SIZE = 8
);
  logic            req0_valid;
  logic            req0_ready;
  logic [1:0]      req0_op;
  logic [SIZE-1:0] req0_a;
  logic [SIZE-1:0] req0_b;
  logic            res0_valid;
  logic            res0_ready;
  logic [SIZE-1:0] res0_data;
  logic            req1_valid;
  logic            req1_ready;
  logic [1:0]      req1_op;
  logic [SIZE-1:0] req1_a;
  logic [SIZE-1:0] req1_b;
  logic            res1_valid;
  logic            res1_ready;
  logic [SIZE-1:0] res1_data;
  logic            busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output res0_ready,
    input  req0_ready, res0_valid, res0_data,
    output req1_valid, req1_op, req1_a, req1_b,
    output res1_ready,
    input  req1_ready, res1_valid, res1_data,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  res0_ready,
    output req0_ready, res0_valid, res0_data,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  res1_ready,
    output req1_ready, res1_valid, res1_data,
    output busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one bitwise logic unit
// between two requesters, one op in flight.
module logic_unit_arbiter #(
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t          r_state;
  logic            r_last_grant;
  logic            r_grant_id;
  logic [1:0]      r_op;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_result;

  logic            w_idle;
  logic            w_done;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_res_hs;
  logic [SIZE-1:0] w_and;
  logic [SIZE-1:0] w_or;
  logic [SIZE-1:0] w_xor;
  logic [SIZE-1:0] w_nor;
  logic [SIZE-1:0] w_result;

  assign w_idle = (r_state == S_IDLE);
  assign w_done = (r_state == S_DONE);

  // a tie goes to whoever was not served last
  assign w_rdy0 = w_idle & bus.req0_valid
                & (~bus.req1_valid | r_last_grant);
  assign w_rdy1 = w_idle & bus.req1_valid
                & (~bus.req0_valid | ~r_last_grant);

  assign w_res_hs = w_done & (r_grant_id ? bus.res1_ready
                                         : bus.res0_ready);

  // XOR and NOR are built from the and/or units
  assign w_and = r_a & r_b;
  assign w_or  = r_a | r_b;
  assign w_xor = w_or & ~w_and;
  assign w_nor = ~w_or;

  // select the result of the latched op
  always_comb begin
    w_result = '0;
    unique case (r_op)
      2'b00: w_result = w_and;
      2'b01: w_result = w_or;
      2'b10: w_result = w_xor;
      2'b11: w_result = w_nor;
      default: w_result = '0;
    endcase
  end

  // accept, execute, then hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rdy0) begin
            r_op       <= bus.req0_op;
            r_a        <= bus.req0_a;
            r_b        <= bus.req0_b;
            r_grant_id <= 1'b0;
            r_state    <= S_EXEC;
          end else if (w_rdy1) begin
            r_op       <= bus.req1_op;
            r_a        <= bus.req1_a;
            r_b        <= bus.req1_b;
            r_grant_id <= 1'b1;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_result;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (w_res_hs) begin
            r_last_grant <= r_grant_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.res0_valid = w_done & ~r_grant_id;
  assign bus.res1_valid = w_done & r_grant_id;
  assign bus.res0_data  = bus.res0_valid ? r_result : '0;
  assign bus.res1_data  = bus.res1_valid ? r_result : '0;
  assign bus.busy       = ~w_idle;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for the shared logic-unit
// arbiter; all checks sampled at negedge.
module tb_logic_unit_arbiter;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic_unit_arbiter_if #(.SIZE(8)) bus ();

  logic_unit_arbiter #(.SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic idle_out(input string tag);
    chk({tag, "_r0v"}, bus.res0_valid, 0);
    chk({tag, "_r1v"}, bus.res1_valid, 0);
    chk({tag, "_r0d"}, bus.res0_data, 0);
    chk({tag, "_r1d"}, bus.res1_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  // one op on a single requester, result taken at once
  task automatic run1(input string tag, input bit n,
                      input logic [1:0] op,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] exp);
    @(negedge clk);
    if (n) begin
      bus.req1_valid = 1; bus.req1_op = op;
      bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1; bus.req0_op = op;
      bus.req0_a = a; bus.req0_b = b;
    end
    bus.res0_ready = 1; bus.res1_ready = 1;
    #1;
    chk({tag, "_rdy0"}, bus.req0_ready, !n);
    chk({tag, "_rdy1"}, bus.req1_ready, n);
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    chk({tag, "_exbusy"}, bus.busy, 1);
    chk({tag, "_exv"}, bus.res0_valid | bus.res1_valid, 0);
    @(negedge clk);
    chk({tag, "_v0"}, bus.res0_valid, !n);
    chk({tag, "_v1"}, bus.res1_valid, n);
    chk({tag, "_d"}, n ? bus.res1_data : bus.res0_data, exp);
    chk({tag, "_dz"}, n ? bus.res0_data : bus.res1_data, 0);
    @(negedge clk);
    idle_out({tag, "_post"});
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1;
    bus.req0_valid = 0; bus.req0_op = 0;
    bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0;
    bus.req1_a = 0; bus.req1_b = 0;
    bus.res0_ready = 0; bus.res1_ready = 0;
    repeat (2) @(negedge clk);
    idle_out("rst");
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    rst = 0;

    // single requester traffic
    run1("or0", 0, 2'b01, 8'hAA, 8'hCC, 8'hEE);
    run1("and1", 1, 2'b00, 8'hFF, 8'h00, 8'h00);
    run1("nor1", 1, 2'b11, 8'hFF, 8'h00, 8'h00);
    run1("xor1", 1, 2'b10, 8'hAA, 8'hCC, 8'h66);

    // both valid from reset: alternate 0,1,0,1
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b10;
    bus.req0_a = 8'hAA; bus.req0_b = 8'hCC;
    bus.req1_valid = 1; bus.req1_op = 2'b01;
    bus.req1_a = 8'h0F; bus.req1_b = 8'hF0;
    bus.res0_ready = 1; bus.res1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_rdy0", i), bus.req0_ready, (i % 2) == 0);
      chk($sformatf("rr%0d_rdy1", i), bus.req1_ready, (i % 2) == 1);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_exrdy", i),
          bus.req0_ready | bus.req1_ready, 0);
      @(negedge clk);
      #1;
      if (i % 2 == 0) begin
        chk($sformatf("rr%0d_v0", i), bus.res0_valid, 1);
        chk($sformatf("rr%0d_d0", i), bus.res0_data, 8'h66);
        chk($sformatf("rr%0d_v1", i), bus.res1_valid, 0);
      end else begin
        chk($sformatf("rr%0d_v1", i), bus.res1_valid, 1);
        chk($sformatf("rr%0d_d1", i), bus.res1_data, 8'hFF);
        chk($sformatf("rr%0d_v0", i), bus.res0_valid, 0);
      end
      @(negedge clk);
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    idle_out("rr_end");

    // backpressure on requester 0 (last_grant is 1)
    bus.res0_ready = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b00;
    bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
    #1;
    chk("bp_rdy0", bus.req0_ready, 1);
    @(negedge clk);
    bus.req1_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_v0", i), bus.res0_valid, 1);
      chk($sformatf("bp%0d_d0", i), bus.res0_data, 8'h30);
      chk($sformatf("bp%0d_busy", i), bus.busy, 1);
      chk($sformatf("bp%0d_rdy", i),
          bus.req0_ready | bus.req1_ready, 0);
      @(negedge clk);
    end
    bus.res0_ready = 1;
    #1;
    chk("bp_rel_v0", bus.res0_valid, 1);
    @(negedge clk);
    #1;
    chk("bp_post_v0", bus.res0_valid, 0);
    chk("bp_post_busy", bus.busy, 0);
    chk("bp_tie_rdy1", bus.req1_ready, 1);
    chk("bp_tie_rdy0", bus.req0_ready, 0);
    bus.req0_valid = 0; bus.req1_valid = 0;
    #1;
    chk("bp_drop_rdy1", bus.req1_ready, 0);

    // reset while requester 1 is in EXEC
    @(negedge clk);
    bus.req1_valid = 1; bus.req1_op = 2'b01;
    bus.req1_a = 8'h0F; bus.req1_b = 8'hF0;
    #1;
    chk("mr_rdy1", bus.req1_ready, 1);
    @(negedge clk);
    bus.req1_valid = 0;
    #1;
    chk("mr_busy", bus.busy, 1);
    rst = 1;
    #1;
    idle_out("mr_rst");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mr%0d_v1", i), bus.res1_valid, 0);
      chk($sformatf("mr%0d_busy", i), bus.busy, 0);
    end
    bus.req0_valid = 1; bus.req0_op = 2'b00;
    bus.req0_a = 8'hF0; bus.req0_b = 8'h3C;
    bus.req1_valid = 1;
    #1;
    chk("mr_tie_rdy0", bus.req0_ready, 1);
    chk("mr_tie_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(negedge clk);
    chk("mr_d0", bus.res0_data, 8'h30);
    @(negedge clk);

    // requester 1 wins the tie, then drops valid
    bus.req0_valid = 1; bus.req0_op = 2'b11;
    bus.req0_a = 8'h0F; bus.req0_b = 8'h30;
    bus.req1_valid = 1; bus.req1_op = 2'b10;
    bus.req1_a = 8'h55; bus.req1_b = 8'h0F;
    #1;
    chk("dr_tie_rdy1", bus.req1_ready, 1);
    bus.req1_valid = 0;
    #1;
    chk("dr_rdy0", bus.req0_ready, 1);
    chk("dr_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    bus.req0_valid = 0;
    @(negedge clk);
    chk("dr_v0", bus.res0_valid, 1);
    chk("dr_d0", bus.res0_data, 8'hC0);
    chk("dr_v1", bus.res1_valid, 0);
    @(negedge clk);
    idle_out("dr_post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
